// File: rtl/multiplier_ctrl_pkg.sv
// Shared types for the RV32M multiply sequencer: opcode and controller state encodings.
package multiplier_ctrl_pkg;

  localparam int MUL_MAX_LAT = 20;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } mulctl_state_t;

endpackage

// File: rtl/multiplier_ctrl_if.sv
// Execute-stage request/response bundle plus the Booth multiplier control lines.
interface multiplier_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [XLEN-1:0]   req_a;
  logic [XLEN-1:0]   req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic              flush;
  logic              mul_en;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic              mul_is_signed_a;
  logic              mul_is_signed_b;
  logic [2*XLEN-1:0] mul_out;
  logic              mul_ready;
  logic              busy;
  logic [CNT_W-1:0]  last_cycles;

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, flush, mul_out, mul_ready,
    output req_ready, resp_valid, resp_data, mul_en, mul_a, mul_b,
           mul_is_signed_a, mul_is_signed_b, busy, last_cycles
  );

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, flush,
    input  req_ready, resp_valid, resp_data, busy, last_cycles
  );

  modport ctrl (
    output mul_en, mul_a, mul_b, mul_is_signed_a, mul_is_signed_b,
    input  mul_out, mul_ready
  );

  modport mult (
    input  mul_en, mul_a, mul_b, mul_is_signed_a, mul_is_signed_b,
    output mul_out, mul_ready
  );
endinterface

// File: rtl/multiplier_ctrl_cache.sv
// Last-product cache for MUL_RESULT_REUSE_EN builds: full 64-bit product tagged by operands and signedness.
module mul_result_cache #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              wr_en,
  input  logic [XLEN-1:0]   wr_a,
  input  logic [XLEN-1:0]   wr_b,
  input  logic              wr_sa,
  input  logic              wr_sb,
  input  logic [2*XLEN-1:0] wr_prod,
  input  logic              inv,
  input  logic [XLEN-1:0]   lk_a,
  input  logic [XLEN-1:0]   lk_b,
  input  logic              lk_sa,
  input  logic              lk_sb,
  output logic              hit,
  output logic [2*XLEN-1:0] prod
);
  logic              valid_q;
  logic [XLEN-1:0]   tag_a_q;
  logic [XLEN-1:0]   tag_b_q;
  logic              tag_sa_q;
  logic              tag_sb_q;
  logic [2*XLEN-1:0] prod_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      valid_q  <= 1'b0;
      tag_a_q  <= '0;
      tag_b_q  <= '0;
      tag_sa_q <= 1'b0;
      tag_sb_q <= 1'b0;
      prod_q   <= '0;
    end else if (inv) begin
      valid_q <= 1'b0;
    end else if (wr_en) begin
      valid_q  <= 1'b1;
      tag_a_q  <= wr_a;
      tag_b_q  <= wr_b;
      tag_sa_q <= wr_sa;
      tag_sb_q <= wr_sb;
      prod_q   <= wr_prod;
    end
  end

  assign hit  = valid_q && (tag_a_q == lk_a) && (tag_b_q == lk_b) &&
                (tag_sa_q == lk_sa) && (tag_sb_q == lk_sb);
  assign prod = prod_q;
endmodule

// File: rtl/multiplier_ctrl.sv
// Sequencer between execute and the iterative Booth multiplier for MUL/MULH/MULHSU/MULHU.
// Build option MUL_RESULT_REUSE_EN adds a last-product cache that bypasses the multiplier on a tag hit.
//
// state | meaning
// IDLE  | ready for a request
// START | one-cycle multiplier start pulse
// WAIT  | counting until the multiplier reports its product
// RESP  | result held for the consumer
// DRAIN | flushed op still running in the multiplier, result discarded
module multiplier_ctrl
  import multiplier_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic               clk,
  input logic               nrst,
  multiplier_ctrl_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mulctl_state_t     state, state_nxt;
  mul_op_t           op_q;
  logic [XLEN-1:0]   a_q, b_q, resp_data_q;
  logic [CNT_W-1:0]  cnt, cnt_inc, last_q;
  logic              accept, capture, hit;
  logic [2*XLEN-1:0] hit_prod;

  function automatic logic [XLEN-1:0] sel_half(input mul_op_t op, input logic [2*XLEN-1:0] p);
    return (op == MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          accept    = 1'b1;
          state_nxt = hit ? RESP : START;
        end
      end
      // mul_ready is not looked at in START: the multiplier only drops it after sampling mul_en
      START: state_nxt = bus.flush ? DRAIN : WAIT;
      WAIT: begin
        if (bus.flush) begin
          state_nxt = DRAIN;
        end else if (bus.mul_ready) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:  if (bus.flush || bus.resp_ready) state_nxt = IDLE;
      DRAIN: if (bus.mul_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      op_q        <= MUL;
      a_q         <= '0;
      b_q         <= '0;
      resp_data_q <= '0;
      cnt         <= '0;
      last_q      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q  <= bus.req_a;
        b_q  <= bus.req_b;
        op_q <= mul_op_t'(bus.req_op);
      end
      if (state == START) cnt <= '0;
      else if (state == WAIT) cnt <= cnt_inc;
      if (capture) begin
        resp_data_q <= sel_half(op_q, bus.mul_out);
        last_q      <= cnt_inc;
      end else if (accept && hit) begin
        resp_data_q <= sel_half(mul_op_t'(bus.req_op), hit_prod);
        last_q      <= '0;
      end
    end
  end

  assign bus.req_ready       = (state == IDLE);
  assign bus.resp_valid      = (state == RESP);
  assign bus.resp_data       = resp_data_q;
  assign bus.mul_en          = (state == START);
  assign bus.mul_a           = a_q;
  assign bus.mul_b           = b_q;
  assign bus.mul_is_signed_a = (op_q != MULHU);
  assign bus.mul_is_signed_b = (op_q == MUL) || (op_q == MULH);
  assign bus.busy            = (state != IDLE);
  assign bus.last_cycles     = last_q;

`ifdef MUL_RESULT_REUSE_EN
  logic req_sa, req_sb;
  assign req_sa = (mul_op_t'(bus.req_op) != MULHU);
  assign req_sb = (mul_op_t'(bus.req_op) == MUL) || (mul_op_t'(bus.req_op) == MULH);

  mul_result_cache #(.XLEN(XLEN)) u_cache (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (capture),
    .wr_a    (a_q),
    .wr_b    (b_q),
    .wr_sa   (bus.mul_is_signed_a),
    .wr_sb   (bus.mul_is_signed_b),
    .wr_prod (bus.mul_out),
    .inv     (bus.flush && (state == DRAIN)),
    .lk_a    (bus.req_a),
    .lk_b    (bus.req_b),
    .lk_sa   (req_sa),
    .lk_sb   (req_sb),
    .hit     (hit),
    .prod    (hit_prod)
  );
`else
  assign hit      = 1'b0;
  assign hit_prod = '0;
`endif
endmodule
